// File: rtl/apb_master_if.sv
// ---------------------------------------------------------------------------
// apb_master_if
// Bundles the command/response handshake and the APB bus of apb_master.
//   cmd_*    : command request from the controller (valid/ready)
//   rsp_*    : single-cycle response pulse back to the controller
//   P*       : APB requester signals toward the slave segment
// Modports:
//   master : the apb_master side (drives cmd_ready, rsp_*, PSEL..PWDATA)
//   slave  : the environment side (controller + APB slave)
// ---------------------------------------------------------------------------
interface apb_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // Command / response
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_error;

  // APB
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic              PREADY;
  logic [DATA_W-1:0] PRDATA;
  logic              PSLVERR;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_error,
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PREADY, PRDATA, PSLVERR
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_error,
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PREADY, PRDATA, PSLVERR
  );
endinterface

// File: rtl/apb_master.sv
// ---------------------------------------------------------------------------
// apb_master
// APB requester: turns a valid/ready command into one APB SETUP/ACCESS
// transfer at a time, honours PREADY wait states and returns read data and
// error status on a one-cycle rsp_valid pulse.
//
// Ports:
//   PCLK     in   clock, rising edge
//   PRESETn  in   asynchronous active-low reset
//   bus      apb_master_if.master (cmd_*, rsp_*, PSEL/PENABLE/PWRITE/PADDR/
//            PWDATA out, PREADY/PRDATA/PSLVERR in)
//
// Parameters: ADDR_W, DATA_W, TIMEOUT_CYCLES (>= 1).
// Optional feature: define APB_MASTER_TIMEOUT_EN to bound the ACCESS phase
// to TIMEOUT_CYCLES cycles; a timed-out transfer responds with rsp_error = 1.
// ---------------------------------------------------------------------------
module apb_master #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic          PCLK,
  input  logic          PRESETn,
  apb_master_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t state;
  state_t state_next;
  logic   accept;
  logic   complete;
  logic   timeout;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt;

  // Counts PREADY-low ACCESS cycles; abort on the last permitted one so
  // ACCESS never exceeds TIMEOUT_CYCLES cycles. PREADY high still wins.
  assign timeout = (state == ACCESS) && !bus.PREADY &&
                   (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      wait_cnt <= '0;
    end else if (state == SETUP) begin
      wait_cnt <= '0;
    end else if (state == ACCESS && !bus.PREADY) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end
`else
  // Timeout disabled: ACCESS waits on PREADY forever.
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state <= IDLE;
    else          state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no branch can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    complete   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.cmd_valid) begin
          accept     = 1'b1;
          state_next = SETUP;
        end
      end
      SETUP:  state_next = ACCESS;
      ACCESS: begin
        if (bus.PREADY || timeout) begin
          complete   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.cmd_ready = (state == IDLE);

  // Registered APB outputs and response. PADDR/PWRITE/PWDATA are only
  // loaded at acceptance and otherwise hold their last value.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      bus.PSEL      <= 1'b0;
      bus.PENABLE   <= 1'b0;
      bus.PWRITE    <= 1'b0;
      bus.PADDR     <= '0;
      bus.PWDATA    <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_error <= 1'b0;
    end else begin
      bus.rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            bus.PADDR  <= bus.cmd_addr;
            bus.PWRITE <= bus.cmd_write;
            bus.PWDATA <= bus.cmd_wdata;
            bus.PSEL   <= 1'b1;
          end
        end
        SETUP: bus.PENABLE <= 1'b1;
        ACCESS: begin
          if (complete) begin
            bus.PSEL      <= 1'b0;
            bus.PENABLE   <= 1'b0;
            bus.rsp_valid <= 1'b1;
            // A timeout only completes when PREADY is low.
            bus.rsp_error <= bus.PREADY ? bus.PSLVERR : 1'b1;
            if (bus.PREADY && !bus.PWRITE) bus.rsp_rdata <= bus.PRDATA;
          end
        end
        default: begin
          bus.PSEL    <= 1'b0;
          bus.PENABLE <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// ---------------------------------------------------------------------------
// tb_apb_master
// Directed bench for apb_master: a small APB slave model with configurable
// wait states, error response and a stuck-low PREADY mode, plus directed
// command sequences with hand-computed expected values.
// ---------------------------------------------------------------------------
module tb_apb_master;

  logic PCLK = 1'b0;
  logic PRESETn;

  always #5 PCLK = ~PCLK;

  apb_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  apb_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(16)) dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- APB slave model ----------------
  logic [31:0] mem [logic [31:0]];
  int   wait_cfg = 0;
  logic err_cfg  = 1'b0;
  logic hang     = 1'b0;
  int   wcnt     = 0;

  // Decides PREADY/PRDATA/PSLVERR for the current cycle at the falling edge;
  // the DUT samples them on the next rising edge.
  always @(negedge PCLK) begin
    if (bus.PSEL && bus.PENABLE) begin
      if (hang || wcnt < wait_cfg) begin
        bus.PREADY  = 1'b0;
        bus.PSLVERR = 1'b0;
        wcnt++;
      end else begin
        bus.PREADY  = 1'b1;
        bus.PSLVERR = err_cfg;
        if (bus.PWRITE) mem[bus.PADDR] = bus.PWDATA;
        wcnt = 0;
      end
      bus.PRDATA = (!bus.PWRITE && mem.exists(bus.PADDR)) ? mem[bus.PADDR] : 32'h0;
    end else begin
      // PREADY high while idle must be ignored by the master.
      bus.PREADY  = 1'b1;
      bus.PSLVERR = 1'b0;
      bus.PRDATA  = 32'hFFFF_FFFF;
      wcnt        = 0;
    end
  end

  // Issues one command starting at a falling edge (the acceptance cycle is
  // cycle 0) and watches the bus until rsp_valid or the cycle budget runs out.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input int budget, output int lat, output int en_cycles,
                      output int bad, output logic got);
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wdata;
    bus.cmd_valid = 1'b1;
    lat = 0; en_cycles = 0; bad = 0; got = 1'b0;
    while (lat < budget && !got) begin
      @(negedge PCLK);
      lat++;
      bus.cmd_valid = 1'b0;
      if (bus.PSEL && (bus.PADDR !== addr || bus.PWRITE !== wr ||
                       (wr && bus.PWDATA !== wdata))) bad++;
      if (bus.PENABLE && !bus.PSEL) bad++;
      if (bus.PENABLE) en_cycles++;
      if (bus.rsp_valid) got = 1'b1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat, en, bad, nrsp, k;
    int   acc [3];
    logic got;

    PRESETn       = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    mem[32'h20]   = 32'h1234_5678;

    // ---- reset state ----
    repeat (2) @(negedge PCLK);
    check("rst_psel",      bus.PSEL,      0);
    check("rst_penable",   bus.PENABLE,   0);
    check("rst_pwrite",    bus.PWRITE,    0);
    check("rst_paddr",     bus.PADDR,     0);
    check("rst_pwdata",    bus.PWDATA,    0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_rdata", bus.rsp_rdata, 0);
    check("rst_rsp_error", bus.rsp_error, 0);
    check("rst_cmd_ready", bus.cmd_ready, 1);
    PRESETn = 1'b1;
    @(negedge PCLK);

    // ---- zero-wait write then read ----
    xfer(1'b1, 32'h10, 32'hDEAD_BEEF, 40, lat, en, bad, got);
    check("wr0_got",       got, 1);
    check("wr0_latency",   lat, 3);
    check("wr0_penable",   en,  1);
    check("wr0_bus",       bad, 0);
    check("wr0_error",     bus.rsp_error, 0);
    check("wr0_rdata",     bus.rsp_rdata, 0);
    check("wr0_ready_rsp", bus.cmd_ready, 1);
    @(negedge PCLK);
    check("wr0_pulse_end", bus.rsp_valid, 0);
    check("wr0_psel_off",  bus.PSEL, 0);
    check("wr0_paddr_hold", bus.PADDR, 32'h10);

    xfer(1'b0, 32'h10, 32'h0, 40, lat, en, bad, got);
    check("rd0_got",     got, 1);
    check("rd0_latency", lat, 3);
    check("rd0_rdata",   bus.rsp_rdata, 32'hDEAD_BEEF);
    check("rd0_error",   bus.rsp_error, 0);
    @(negedge PCLK);

    // ---- four wait states on a read ----
    wait_cfg = 4;
    xfer(1'b0, 32'h20, 32'h0, 40, lat, en, bad, got);
    wait_cfg = 0;
    check("wait_got",     got, 1);
    check("wait_latency", lat, 7);
    check("wait_penable", en,  5);
    check("wait_bus",     bad, 0);
    check("wait_rdata",   bus.rsp_rdata, 32'h1234_5678);
    @(negedge PCLK);

    // ---- slave error, then clean transfer ----
    err_cfg = 1'b1;
    xfer(1'b1, 32'h30, 32'h0000_0055, 40, lat, en, bad, got);
    err_cfg = 1'b0;
    check("err_got",   got, 1);
    check("err_error", bus.rsp_error, 1);
    check("err_rdata_held", bus.rsp_rdata, 32'h1234_5678);
    @(negedge PCLK);
    xfer(1'b0, 32'h10, 32'h0, 40, lat, en, bad, got);
    check("clr_error", bus.rsp_error, 0);
    check("clr_rdata", bus.rsp_rdata, 32'hDEAD_BEEF);
    @(negedge PCLK);

    // ---- back-to-back writes with cmd_valid held ----
    k = 0; nrsp = 0; bad = 0;
    acc[0] = -1; acc[1] = -1; acc[2] = -1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 32'h0;
    bus.cmd_wdata = 32'hA0;
    bus.cmd_valid = 1'b1;
    for (int t = 0; t < 14; t++) begin
      if (bus.PSEL && bus.PADDR !== 32'(4 * (k - 1))) bad++;
      if (bus.PENABLE && !bus.PSEL) bad++;
      if (bus.rsp_valid) nrsp++;
      if (bus.cmd_valid && bus.cmd_ready) begin
        acc[k] = t;
        k++;
      end
      @(negedge PCLK);
      if (k < 3) begin
        bus.cmd_addr  = 32'(4 * k);
        bus.cmd_wdata = 32'(32'hA0 + k);
      end else begin
        bus.cmd_valid = 1'b0;
      end
    end
    check("b2b_accepts", k, 3);
    check("b2b_gap1",    acc[1] - acc[0], 3);
    check("b2b_gap2",    acc[2] - acc[1], 3);
    check("b2b_rsps",    nrsp, 3);
    check("b2b_paddr",   bad, 0);
    xfer(1'b0, 32'h8, 32'h0, 40, lat, en, bad, got);
    check("b2b_readback", bus.rsp_rdata, 32'hA2);
    @(negedge PCLK);

    // ---- PREADY stuck low ----
    hang = 1'b1;
    xfer(1'b0, 32'h40, 32'h0, 100, lat, en, bad, got);
`ifdef APB_MASTER_TIMEOUT_EN
    check("to_got",       got, 1);
    check("to_latency",   lat, 18);
    check("to_penable",   en,  16);
    check("to_error",     bus.rsp_error, 1);
    check("to_rdata_held", bus.rsp_rdata, 32'hA2);
    @(negedge PCLK);
    // Start another stuck transfer so reset lands in an ACCESS wait.
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 32'h40;
    bus.cmd_valid = 1'b1;
    @(negedge PCLK);
    bus.cmd_valid = 1'b0;
    repeat (3) @(negedge PCLK);
`else
    check("hang_no_rsp",  got, 0);
    check("hang_penable", en,  99);
`endif

    // ---- reset during an ACCESS wait ----
    check("pre_rst_penable", bus.PENABLE, 1);
    check("pre_rst_paddr",   bus.PADDR, 32'h40);
    PRESETn = 1'b0;
    #1;
    check("mid_rst_psel",      bus.PSEL,      0);
    check("mid_rst_penable",   bus.PENABLE,   0);
    check("mid_rst_paddr",     bus.PADDR,     0);
    check("mid_rst_pwdata",    bus.PWDATA,    0);
    check("mid_rst_rsp_valid", bus.rsp_valid, 0);
    check("mid_rst_rsp_rdata", bus.rsp_rdata, 0);
    check("mid_rst_rsp_error", bus.rsp_error, 0);
    check("mid_rst_cmd_ready", bus.cmd_ready, 1);
    @(negedge PCLK);
    PRESETn = 1'b1;
    hang    = 1'b0;
    nrsp    = 0;
    repeat (5) begin
      @(negedge PCLK);
      if (bus.rsp_valid) nrsp++;
    end
    check("post_rst_no_rsp", nrsp, 0);
    check("post_rst_ready",  bus.cmd_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
